// File: rtl/keypad_scanner_pkg.sv
// keypad_pkg: keypad geometry, one-hot key codes and scanner state encoding.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 12;
  localparam logic [NUM_KEYS-1:0] KEY_1    = 12'h001;
  localparam logic [NUM_KEYS-1:0] KEY_2    = 12'h002;
  localparam logic [NUM_KEYS-1:0] KEY_3    = 12'h004;
  localparam logic [NUM_KEYS-1:0] KEY_4    = 12'h008;
  localparam logic [NUM_KEYS-1:0] KEY_5    = 12'h010;
  localparam logic [NUM_KEYS-1:0] KEY_6    = 12'h020;
  localparam logic [NUM_KEYS-1:0] KEY_7    = 12'h040;
  localparam logic [NUM_KEYS-1:0] KEY_8    = 12'h080;
  localparam logic [NUM_KEYS-1:0] KEY_9    = 12'h100;
  localparam logic [NUM_KEYS-1:0] KEY_STAR = 12'h200;
  localparam logic [NUM_KEYS-1:0] KEY_0    = 12'h400;
  localparam logic [NUM_KEYS-1:0] KEY_HASH = 12'h800;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix lines plus the key-code strobe to the display stage.
interface keypad_scanner_if;
  import keypad_pkg::*;
  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  logic [NUM_KEYS-1:0] scan_data;
  logic                valid;
  modport master (input row, output col, scan_data, valid);
  modport slave (output row, input col, scan_data, valid);
endinterface

// File: rtl/keypad_scanner_sync2.sv
// sync2: parameterized-width two-flop synchronizer with synchronous clear.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanned 4x3 keypad with frame debounce, one one-hot code pulse per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);
  logic [NUM_ROWS-1:0] row_s;
  logic [DW-1:0]       div;
  logic [NUM_COLS-1:0] col;
  logic [NUM_KEYS-1:0] frame, frame_nx, cand, cand_nx, scan_data;
  logic [CW-1:0]       cnt, cnt_nx, cnt_inc;
  state_t              state, state_nx;
  logic                last, frame_end, none, single, accept, valid;
  sync2 #(.W(NUM_ROWS)) u_sync (.clk(clk), .rst(rst), .d(kp.row), .q(row_s));
  assign last      = div == DIV_LAST;
  assign frame_end = last && col[NUM_COLS-1];
  assign cnt_inc   = cnt == CNT_MAX ? cnt : cnt + 1'b1;
  // Frame including the sample taken this clock, so the frame-end evaluation sees all columns.
  always_comb begin
    frame_nx = frame;
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        if (col[c]) frame_nx[r*NUM_COLS+c] = row_s[r];
  end
  assign none   = frame_nx == '0;
  assign single = $countones(frame_nx) == 1;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (frame_end)
      case (state)
        SCAN: if (single) begin
          cand_nx = frame_nx;
          if (DEBOUNCE_SCANS == 1) begin
            accept   = 1'b1;
            state_nx = HELD;
            cnt_nx   = '0;
          end else begin
            state_nx = DEBOUNCE;
            cnt_nx   = CW'(1);
          end
        end
        DEBOUNCE: if (single && frame_nx == cand) begin
          accept   = cnt_inc == CNT_MAX;
          state_nx = accept ? HELD : DEBOUNCE;
          cnt_nx   = accept ? '0 : cnt_inc;
        end else begin
          state_nx = SCAN;
          cnt_nx   = '0;
        end
        HELD: if (none) begin
          state_nx = DEBOUNCE_SCANS == 1 ? SCAN : RELEASE;
          cnt_nx   = DEBOUNCE_SCANS == 1 ? '0 : CW'(1);
        end
        RELEASE: if (none) begin
          state_nx = cnt_inc == CNT_MAX ? SCAN : RELEASE;
          cnt_nx   = cnt_inc == CNT_MAX ? '0 : cnt_inc;
        end else begin
          state_nx = HELD;
          cnt_nx   = '0;
        end
        default: state_nx = SCAN;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      col       <= NUM_COLS'(1);
      frame     <= '0;
      state     <= SCAN;
      cnt       <= '0;
      cand      <= '0;
      scan_data <= '0;
      valid     <= 1'b0;
    end else begin
      div   <= last ? '0 : div + 1'b1;
      col   <= last ? {col[NUM_COLS-2:0], col[NUM_COLS-1]} : col;
      frame <= last ? frame_nx : frame;
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
      valid <= accept;
      if (accept) scan_data <= cand_nx;
    end
  end
  assign kp.col       = col;
  assign kp.scan_data = scan_data;
  assign kp.valid     = valid;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed press/bounce/chord/reset scenarios against a combinational keypad model.
module tb_keypad_scanner;
  import keypad_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          vcnt = 0;
  int          v0 = 0;
  keypad_scanner_if kp();
  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (.clk(clk), .rst(rst), .kp(kp.master));
  always #5 clk = ~clk;
  assign kp.row = {|(keys[9+:3] & kp.col), |(keys[6+:3] & kp.col),
                   |(keys[3+:3] & kp.col), |(keys[0+:3] & kp.col)};
  always @(negedge clk) if (kp.valid) vcnt++;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(3);
    chk("rst_col", 32'(kp.col), 32'h1);
    chk("rst_data", 32'(kp.scan_data), 32'h0);
    chk("rst_valid", 32'(kp.valid), 32'h0);
    rst = 1'b0;
    tick(1);
    chk("col_p1", 32'(kp.col), 32'h1);
    tick(3);
    chk("col_p4", 32'(kp.col), 32'h2);
    tick(4);
    chk("col_p8", 32'(kp.col), 32'h4);
    tick(4);
    chk("col_p12", 32'(kp.col), 32'h1);
    keys = KEY_5;
    tick(35);
    chk("k5_early", 32'(kp.valid), 32'h0);
    tick(1);
    chk("k5_valid", 32'(kp.valid), 32'h1);
    chk("k5_data", 32'(kp.scan_data), 32'h010);
    tick(1);
    chk("k5_pulse_end", 32'(kp.valid), 32'h0);
    tick(83);
    chk("k5_one_pulse", 32'(vcnt), 32'd1);
    keys = '0;
    tick(60);
    chk("k5_release_data", 32'(kp.scan_data), 32'h010);
    keys = KEY_HASH;
    tick(36);
    chk("hash_valid", 32'(kp.valid), 32'h1);
    chk("hash_data", 32'(kp.scan_data), 32'h800);
    tick(1);
    chk("hash_pulse_end", 32'(kp.valid), 32'h0);
    chk("hash_count", 32'(vcnt), 32'd2);
    keys = '0;
    tick(60);
    v0 = vcnt;
    keys = KEY_7;
    tick(12);
    keys = '0;
    tick(12);
    keys = KEY_7;
    tick(24);
    chk("bounce_no_pulse", 32'(vcnt - v0), 32'd0);
    tick(60);
    chk("bounce_one_pulse", 32'(vcnt - v0), 32'd1);
    chk("bounce_data", 32'(kp.scan_data), 32'h040);
    keys = '0;
    tick(60);
    v0 = vcnt;
    keys = KEY_1 | KEY_2;
    tick(72);
    chk("chord_no_pulse", 32'(vcnt - v0), 32'd0);
    chk("chord_data", 32'(kp.scan_data), 32'h040);
    keys = KEY_1;
    tick(60);
    chk("k1_pulse", 32'(vcnt - v0), 32'd1);
    chk("k1_data", 32'(kp.scan_data), 32'h001);
    keys = KEY_1 | KEY_3;
    tick(60);
    chk("held_chord_ignored", 32'(vcnt - v0), 32'd1);
    chk("held_chord_data", 32'(kp.scan_data), 32'h001);
    keys = '0;
    tick(60);
    v0 = vcnt;
    keys = KEY_STAR;
    tick(60);
    chk("star_pulse", 32'(vcnt - v0), 32'd1);
    chk("star_data", 32'(kp.scan_data), 32'h200);
    keys = '0;
    tick(12);
    keys = KEY_STAR;
    tick(60);
    chk("rel_bounce_no_pulse", 32'(vcnt - v0), 32'd1);
    chk("rel_bounce_data", 32'(kp.scan_data), 32'h200);
    keys = '0;
    tick(60);
    v0 = vcnt;
    keys = KEY_0;
    tick(24);
    chk("mid_db_no_pulse", 32'(vcnt - v0), 32'd0);
    rst = 1'b1;
    tick(2);
    chk("mid_rst_data", 32'(kp.scan_data), 32'h0);
    chk("mid_rst_col", 32'(kp.col), 32'h1);
    rst = 1'b0;
    tick(35);
    chk("after_rst_early", 32'(kp.valid), 32'h0);
    chk("after_rst_no_pulse", 32'(vcnt - v0), 32'd0);
    tick(1);
    chk("after_rst_valid", 32'(kp.valid), 32'h1);
    chk("after_rst_data", 32'(kp.scan_data), 32'h400);
    tick(1);
    chk("after_rst_pulse_end", 32'(kp.valid), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
